// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle control unit for the MIPS-subset datapath.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It adds a data-memory
// wait counter, a global hold, illegal-opcode detection and a retired-instruction counter.
// Optional feature macro: CTRL_BGEZAL_EN. When it is defined, bgezal is decoded.
// When it is undefined, op 000001 is illegal.
// The state register is exported on the 'state' port so that checkers can bind to it.
// The datapath mux selects are registered.
// The write enables and pulses are decoded from the registered state. They are gated by
// hold, reset, zero and sign in the same cycle.
module multi_cycle_ctrl #(
  parameter int ALUC_W  = 3,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [4:0]        rt,
  input  logic              zero,
  input  logic              sign,
  input  logic              hold,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              GRFWrite,
  output logic              DMWrite,
  output logic [1:0]        pc_sel,
  output logic [1:0]        GRFDst,
  output logic              ALUSrc,
  output logic              DMtoGRF,
  output logic              LUI,
  output logic              signSrc,
  output logic [ALUC_W-1:0] ALUC,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam int MCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ,
    C_LUI, C_J, C_JAL, C_BGEZAL, C_ILL
  } cls_t;

  state_t         st;
  cls_t           cls;
  cls_t           dec;
  logic [MCW-1:0] mem_cnt;
  logic           dm_done;
  logic [2:0]     alu_c;
  logic           alu_src, sign_src, lui_r, dm_to_grf;
  logic [1:0]     grf_dst;
  logic           bgezal_hit;
  logic           is_last;
  logic [2:0]     d_aluc;
  logic           d_alusrc, d_signsrc, d_lui;
  logic [1:0]     d_grfdst;

`ifdef CTRL_BGEZAL_EN
  assign bgezal_hit = (op == 6'b000001) && (rt == 5'b10001);
`else
  // Without bgezal, op 000001 stays illegal and rt carries no meaning.
  logic unused_rt;
  assign unused_rt  = ^rt;
  assign bgezal_hit = 1'b0;
`endif

  // Decode the live instruction fields. They are consumed only while in DECODE.
  always_comb begin
    dec = C_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: dec = C_ADDU;
          6'b100011: dec = C_SUBU;
          6'b001000: dec = C_JR;
          default:   dec = C_ILL;
        endcase
      end
      6'b001101: dec = C_ORI;
      6'b100011: dec = C_LW;
      6'b101011: dec = C_SW;
      6'b000100: dec = C_BEQ;
      6'b001111: dec = C_LUI;
      6'b000010: dec = C_J;
      6'b000011: dec = C_JAL;
      6'b000001: dec = bgezal_hit ? C_BGEZAL : C_ILL;
      default:   dec = C_ILL;
    endcase
  end

  // Per-class mux values. These are loaded into the select registers when DECODE exits.
  always_comb begin
    d_aluc    = 3'b000;
    d_alusrc  = 1'b0;
    d_signsrc = 1'b0;
    d_lui     = 1'b0;
    d_grfdst  = 2'b00;
    case (dec)
      C_ADDU:   begin d_aluc = 3'b010; d_grfdst = 2'b01; end
      C_SUBU:   begin d_aluc = 3'b110; d_grfdst = 2'b01; end
      C_ORI:    begin d_aluc = 3'b001; d_alusrc = 1'b1; d_signsrc = 1'b1; end
      C_LUI:    begin d_aluc = 3'b001; d_alusrc = 1'b1; d_lui = 1'b1; end
      C_LW:     begin d_aluc = 3'b010; d_alusrc = 1'b1; end
      C_SW:     begin d_aluc = 3'b010; d_alusrc = 1'b1; end
      C_JAL:    d_grfdst = 2'b10;
      C_BGEZAL: d_grfdst = 2'b10;
      default:  d_aluc = 3'b000;
    endcase
  end

  // Flag the cycle whose successor is FETCH, i.e. the final cycle of the instruction.
  always_comb begin
    is_last = 1'b0;
    case (st)
      S_DECODE: is_last = (dec == C_J) || (dec == C_JR) || (dec == C_ILL);
      S_EXEC:   is_last = (cls == C_BEQ);
      S_MEM:    is_last = (mem_cnt == '0) && (cls == C_SW);
      S_WB:     is_last = 1'b1;
      default:  is_last = 1'b0;
    endcase
  end

  assign instr_done = is_last && !hold && reset;
  assign illegal    = (st == S_DECODE) && (dec == C_ILL) && !hold && reset;

  // Sequencer: state, latched class, MEM wait counter, registered selects, retired count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_FETCH;
      cls       <= C_NONE;
      mem_cnt   <= '0;
      dm_done   <= 1'b0;
      alu_c     <= 3'b000;
      alu_src   <= 1'b0;
      sign_src  <= 1'b0;
      lui_r     <= 1'b0;
      dm_to_grf <= 1'b0;
      grf_dst   <= 2'b00;
      retired   <= '0;
    end else if (!hold) begin
      case (st)
        S_FETCH: st <= S_DECODE;
        S_DECODE: begin
          cls      <= dec;
          alu_c    <= d_aluc;
          alu_src  <= d_alusrc;
          sign_src <= d_signsrc;
          lui_r    <= d_lui;
          grf_dst  <= d_grfdst;
          if (dec == C_JAL)
            st <= S_WB;
          else if ((dec == C_J) || (dec == C_JR) || (dec == C_ILL))
            st <= S_FETCH;
          else
            st <= S_EXEC;
        end
        S_EXEC: begin
          if ((cls == C_LW) || (cls == C_SW)) begin
            st        <= S_MEM;
            mem_cnt   <= MCW'(MEM_LAT - 1);
            dm_done   <= 1'b0;
            dm_to_grf <= (cls == C_LW);
          end else if (cls == C_BEQ) begin
            st <= S_FETCH;
          end else begin
            st <= S_WB;
          end
        end
        S_MEM: begin
          // The first non-held MEM cycle consumes the single sw write.
          dm_done <= 1'b1;
          if (mem_cnt == '0)
            st <= (cls == C_LW) ? S_WB : S_FETCH;
          else
            mem_cnt <= mem_cnt - 1'b1;
        end
        S_WB:    st <= S_FETCH;
        default: st <= S_FETCH;
      endcase
      // When an instruction ends, clear the class and selects so that FETCH starts clean.
      if (instr_done) begin
        cls       <= C_NONE;
        alu_c     <= 3'b000;
        alu_src   <= 1'b0;
        sign_src  <= 1'b0;
        lui_r     <= 1'b0;
        dm_to_grf <= 1'b0;
        grf_dst   <= 2'b00;
        if (!illegal)
          retired <= retired + 1'b1;
      end
    end
  end

  // Write enables and pc_sel are derived from the state.
  // hold forces the enables to zero and leaves the selects untouched.
  // reset low forces everything to zero.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    GRFWrite = 1'b0;
    DMWrite  = 1'b0;
    pc_sel   = 2'b00;
    case (st)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        if ((dec == C_J) || (dec == C_JAL)) begin
          PCWrite = 1'b1;
          pc_sel  = 2'b10;
        end else if (dec == C_JR) begin
          PCWrite = 1'b1;
          pc_sel  = 2'b11;
        end
      end
      S_EXEC: begin
        if (cls == C_BEQ) begin
          PCWrite = zero;
          pc_sel  = 2'b01;
        end else if (cls == C_BGEZAL) begin
          PCWrite = ~sign;
          pc_sel  = 2'b01;
        end
      end
      S_MEM:   DMWrite  = (cls == C_SW) && !dm_done;
      S_WB:    GRFWrite = 1'b1;
      default: PCWrite  = 1'b0;
    endcase
    if (hold || !reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      GRFWrite = 1'b0;
      DMWrite  = 1'b0;
    end
    if (!reset)
      pc_sel = 2'b00;
  end

  assign state   = st;
  assign ALUC    = ALUC_W'(alu_c);
  assign ALUSrc  = alu_src;
  assign signSrc = sign_src;
  assign LUI     = lui_r;
  assign DMtoGRF = dm_to_grf;
  assign GRFDst  = grf_dst;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: randomized bench for multi_cycle_ctrl.
// Two instances are used, dut1 with MEM_LAT=1 and dut3 with MEM_LAT=3. Only one is active
// at a time; the other is held in reset, and its outputs must read all zero.
// The reference model lists the per-cycle control word of each instruction.
// It derives that list from the instruction's state sequence and the output rules.
// Holds and resets are then woven in around that list.
module tb_multi_cycle_ctrl;

`ifdef CTRL_BGEZAL_EN
  localparam bit BGZ_EN = 1'b1;
`else
  localparam bit BGZ_EN = 1'b0;
`endif

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_BGEZAL = 10, K_ILL = 11,
                 K_ILL_FF = 12;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, grfw, dmw;
    logic [1:0] pc_sel, grfdst;
    logic       alusrc, dmtogrf, lui, signsrc;
    logic [3:0] aluc;
    logic       done, ill;
  } out_t;

  typedef struct packed {
    out_t o;
    logic pcsel_care;
    logic grfdst_care;
    logic inc;
  } exp_t;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1, reset3, hold, zero, sign;
  logic [5:0] op, funct;
  logic [4:0] rt;

  logic        pcw1, irw1, grfw1, dmw1, alusrc1, dmtogrf1, lui1, signsrc1, done1, ill1;
  logic [1:0]  pcsel1, grfdst1;
  logic [2:0]  aluc1, state1;
  logic [31:0] ret1;
  logic        pcw3, irw3, grfw3, dmw3, alusrc3, dmtogrf3, lui3, signsrc3, done3, ill3;
  logic [1:0]  pcsel3, grfdst3;
  logic [3:0]  aluc3;
  logic [2:0]  state3;
  logic [3:0]  ret3;

  multi_cycle_ctrl #(.ALUC_W(3), .MEM_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset1), .op(op), .funct(funct), .rt(rt), .zero(zero), .sign(sign),
    .hold(hold), .PCWrite(pcw1), .IRWrite(irw1), .GRFWrite(grfw1), .DMWrite(dmw1),
    .pc_sel(pcsel1), .GRFDst(grfdst1), .ALUSrc(alusrc1), .DMtoGRF(dmtogrf1), .LUI(lui1),
    .signSrc(signsrc1), .ALUC(aluc1), .state(state1), .instr_done(done1), .illegal(ill1),
    .retired(ret1));

  multi_cycle_ctrl #(.ALUC_W(4), .MEM_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset3), .op(op), .funct(funct), .rt(rt), .zero(zero), .sign(sign),
    .hold(hold), .PCWrite(pcw3), .IRWrite(irw3), .GRFWrite(grfw3), .DMWrite(dmw3),
    .pc_sel(pcsel3), .GRFDst(grfdst3), .ALUSrc(alusrc3), .DMtoGRF(dmtogrf3), .LUI(lui3),
    .signSrc(signsrc3), .ALUC(aluc3), .state(state3), .instr_done(done3), .illegal(ill3),
    .retired(ret3));

  out_t obs1, obs3;
  assign obs1 = {state1, pcw1, irw1, grfw1, dmw1, pcsel1, grfdst1, alusrc1, dmtogrf1,
                 lui1, signsrc1, 1'b0, aluc1, done1, ill1};
  assign obs3 = {state3, pcw3, irw3, grfw3, dmw3, pcsel3, grfdst3, alusrc3, dmtogrf3,
                 lui3, signsrc3, aluc3, done3, ill3};

  // ---------------- scoreboard state ----------------
  logic [$bits(exp_t)-1:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_ret = 0;
  bit          use3    = 1'b0;
  int          cur_lat = 1;
  bit          rand_holds = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t exp_for(int k, int s, bit first_mem, bit last, bit z, bit sg);
    exp_t e;
    e = '0;
    e.o.st = 3'(s);
    if (s >= 2) begin
      if (k == K_ADDU || k == K_LW || k == K_SW) e.o.aluc = 4'd2;
      else if (k == K_SUBU)                      e.o.aluc = 4'd6;
      else if (k == K_ORI || k == K_LUI)         e.o.aluc = 4'd1;
      e.o.alusrc  = (k == K_ORI || k == K_LW || k == K_SW || k == K_LUI);
      e.o.signsrc = (k == K_ORI);
      e.o.lui     = (k == K_LUI);
    end
    case (s)
      0: begin e.o.irw = 1'b1; e.o.pcw = 1'b1; e.o.pc_sel = 2'b00; e.pcsel_care = 1'b1; end
      1: begin
        if (k == K_J || k == K_JAL) begin
          e.o.pcw = 1'b1; e.o.pc_sel = 2'b10; e.pcsel_care = 1'b1;
        end else if (k == K_JR) begin
          e.o.pcw = 1'b1; e.o.pc_sel = 2'b11; e.pcsel_care = 1'b1;
        end else if (k == K_ILL) begin
          e.o.ill = 1'b1;
        end
      end
      2: begin
        if (k == K_BEQ) begin
          e.o.pcw = z; e.o.pc_sel = 2'b01; e.pcsel_care = 1'b1;
        end else if (k == K_BGEZAL) begin
          e.o.pcw = !sg; e.o.pc_sel = 2'b01; e.pcsel_care = 1'b1;
        end
      end
      3: begin
        e.o.dmw     = (k == K_SW) && first_mem;
        e.o.dmtogrf = (k == K_LW);
      end
      4: begin
        e.o.grfw    = 1'b1;
        e.o.dmtogrf = (k == K_LW);
        e.grfdst_care = 1'b1;
        if (k == K_ADDU || k == K_SUBU)        e.o.grfdst = 2'b01;
        else if (k == K_JAL || k == K_BGEZAL)  e.o.grfdst = 2'b10;
        else                                   e.o.grfdst = 2'b00;
      end
      default: e.o.st = 3'(s);
    endcase
    e.o.done = last;
    e.inc    = last && (k != K_ILL);
    return e;
  endfunction

  function automatic void build(int k, int lat, bit z, bit sg);
    int seq[$];
    seq = '{0, 1};
    if (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_BGEZAL) begin
      seq.push_back(2); seq.push_back(4);
    end else if (k == K_LW || k == K_SW) begin
      seq.push_back(2);
      for (int m = 0; m < lat; m++) seq.push_back(3);
      if (k == K_LW) seq.push_back(4);
    end else if (k == K_BEQ) begin
      seq.push_back(2);
    end else if (k == K_JAL) begin
      seq.push_back(4);
    end
    for (int i = 0; i < seq.size(); i++)
      exp_q.push_back(exp_for(k, seq[i], (seq[i] == 3) && (i > 0) && (seq[i-1] != 3),
                              i == seq.size() - 1, z, sg));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic encode(input int k, output logic [5:0] o, output logic [5:0] f,
                        output logic [4:0] r);
    o = 6'($urandom); f = 6'($urandom); r = 5'($urandom);
    case (k)
      K_ADDU:   begin o = 6'b000000; f = 6'b100001; end
      K_SUBU:   begin o = 6'b000000; f = 6'b100011; end
      K_JR:     begin o = 6'b000000; f = 6'b001000; end
      K_ORI:    o = 6'b001101;
      K_LW:     o = 6'b100011;
      K_SW:     o = 6'b101011;
      K_BEQ:    o = 6'b000100;
      K_LUI:    o = 6'b001111;
      K_J:      o = 6'b000010;
      K_JAL:    o = 6'b000011;
      K_BGEZAL: begin o = 6'b000001; r = 5'b10001; end
      K_ILL_FF: o = 6'b111111;
      default: begin
        case ($urandom_range(3, 0))
          0: o = 6'b111111;
          1: begin
            o = 6'b000000;
            while (f == 6'b100001 || f == 6'b100011 || f == 6'b001000) f = 6'($urandom);
          end
          2: begin o = 6'b000001; if (r == 5'b10001) r = 5'b10000; end
          default: o = ($urandom_range(1, 0) == 0) ? 6'b001000 : 6'b000101;
        endcase
      end
    endcase
  endtask

  task automatic compare(input bit h, input exp_t e);
    out_t x, g;
    x = e.o;
    if (h) begin
      x.pcw = 1'b0; x.irw = 1'b0; x.grfw = 1'b0; x.dmw = 1'b0; x.done = 1'b0; x.ill = 1'b0;
    end
    g = use3 ? obs3 : obs1;
    check_val("state", 64'(g.st), 64'(x.st));
    check_val("enables", 64'({g.pcw, g.irw, g.grfw, g.dmw}), 64'({x.pcw, x.irw, x.grfw, x.dmw}));
    check_val("selects", 64'({g.alusrc, g.dmtogrf, g.lui, g.signsrc, g.aluc}),
              64'({x.alusrc, x.dmtogrf, x.lui, x.signsrc, x.aluc}));
    if (e.pcsel_care)  check_val("pc_sel", 64'(g.pc_sel), 64'(x.pc_sel));
    if (e.grfdst_care) check_val("grfdst", 64'(g.grfdst), 64'(x.grfdst));
    check_val("pulses", 64'({g.done, g.ill}), 64'({x.done, x.ill}));
    if (use3) check_val("retired", 64'(ret3), 64'(exp_ret[3:0]));
    else      check_val("retired", 64'(ret1), 64'(exp_ret));
    if (use3) check_val("idle_dut_zero", 64'({obs1, ret1}), 64'(0));
    else      check_val("idle_dut_zero", 64'({obs3, ret3}), 64'(0));
  endtask

  // One clock cycle: the instruction fields are valid only in DECODE and are noise elsewhere.
  task automatic cycle(input bit h, input exp_t e, input logic [5:0] io,
                       input logic [5:0] ifn, input logic [4:0] ir);
    hold = h;
    if (e.o.st == 3'd1) begin
      op = io; funct = ifn; rt = ir;
    end else begin
      op = 6'($urandom); funct = 6'($urandom); rt = 5'($urandom);
    end
    @(negedge clk);
    compare(h, e);
    @(posedge clk);
    #1;
    if (!h && e.inc) exp_ret++;
  endtask

  task automatic reset_abort();
    if (use3) reset3 = 1'b0; else reset1 = 1'b0;
    hold = 1'b0;
    exp_ret = 0;
    repeat (2) begin
      op = 6'($urandom); funct = 6'($urandom); rt = 5'($urandom);
      @(negedge clk);
      if (use3) check_val("reset_outputs", 64'({obs3, ret3}), 64'(0));
      else      check_val("reset_outputs", 64'({obs1, ret1}), 64'(0));
      @(posedge clk);
      #1;
    end
    if (use3) reset3 = 1'b1; else reset1 = 1'b1;
  endtask

  task automatic run_instr(input int k, input bit z, input bit sg, input int hold_at,
                           input int hold_n, input int abort_at);
    logic [5:0] io, ifn;
    logic [4:0] ir;
    int   eff, i, nh;
    exp_t e;
    bit   aborted;
    encode(k, io, ifn, ir);
    eff = (k == K_ILL_FF) ? K_ILL : k;
    if (eff == K_BGEZAL && !BGZ_EN) eff = K_ILL;
    zero = z; sign = sg;
    build(eff, cur_lat, z, sg);
    i = 0; aborted = 1'b0;
    while (exp_q.size() > 0 && !aborted) begin
      e = exp_t'(exp_q.pop_front());
      if (i == abort_at) begin
        reset_abort();
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        nh = 0;
        if (i == hold_at) nh = hold_n;
        else if (rand_holds && $urandom_range(3, 0) == 0) nh = int'($urandom_range(2, 1));
        repeat (nh) cycle(1'b1, e, io, ifn, ir);
        cycle(1'b0, e, io, ifn, ir);
        i++;
      end
    end
    hold = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset1 = 1'b0; reset3 = 1'b0; hold = 1'b0; zero = 1'b0; sign = 1'b0;
    op = 6'd0; funct = 6'd0; rt = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_dut1", 64'({obs1, ret1}), 64'(0));
    check_val("reset_dut3", 64'({obs3, ret3}), 64'(0));
    @(posedge clk);
    #1;
    reset1 = 1'b1;

    // Directed cases on the MEM_LAT=1 instance.
    run_instr(K_ADDU, 1'b0, 1'b0, -1, 0, -1);
    run_instr(K_LW,   1'b0, 1'b0, -1, 0, -1);
    run_instr(K_BEQ,  1'b1, 1'b0, -1, 0, -1);
    run_instr(K_BEQ,  1'b0, 1'b0, -1, 0, -1);
    run_instr(K_BGEZAL, 1'b0, 1'b1, -1, 0, -1);
    run_instr(K_BGEZAL, 1'b0, 1'b0, -1, 0, -1);
    run_instr(K_ILL_FF, 1'b0, 1'b0, -1, 0, -1);
    run_instr(K_JAL,  1'b0, 1'b0, -1, 0, -1);
    run_instr(K_J,    1'b0, 1'b0, -1, 0, -1);
    run_instr(K_JR,   1'b0, 1'b0, -1, 0, -1);
    run_instr(K_SW,   1'b0, 1'b0, -1, 0, -1);
    run_instr(K_SUBU, 1'b0, 1'b0, -1, 0, -1);
    run_instr(K_ORI,  1'b0, 1'b0, -1, 0, -1);
    run_instr(K_LUI,  1'b0, 1'b0, -1, 0, -1);
    run_instr(K_ADDU, 1'b0, 1'b0, 2, 5, -1);
    run_instr(K_J,    1'b0, 1'b0, 1, 2, -1);
    rand_holds = 1'b1;
    repeat (60)
      run_instr(int'($urandom_range(11, 0)), 1'(($urandom)), 1'(($urandom)), -1, 0, -1);
    rand_holds = 1'b0;

    // Switch to the MEM_LAT=3, 4-bit counter instance.
    reset1 = 1'b0; reset3 = 1'b1; use3 = 1'b1; cur_lat = 3; exp_ret = 0;
    run_instr(K_SW,   1'b0, 1'b0, -1, 0, -1);
    run_instr(K_SW,   1'b0, 1'b0, 3, 2, -1);
    run_instr(K_LW,   1'b0, 1'b0, -1, 0, -1);
    run_instr(K_LW,   1'b0, 1'b0, -1, 0, 4);
    run_instr(K_ADDU, 1'b0, 1'b0, 2, 5, -1);
    run_instr(K_ORI,  1'b0, 1'b0, -1, 0, -1);
    rand_holds = 1'b1;
    repeat (40)
      run_instr(int'($urandom_range(11, 0)), 1'(($urandom)), 1'(($urandom)), -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control unit for the MIPS-subset datapath. Replaces the single-cycle combinational decoder with a state machine that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same control signal set per state. Adds a parametrised data-memory wait counter, a global hold, illegal-opcode detection and a retired-instruction counter. Sits between the instruction register and the datapath muxes and enables.

## Interface
Parameters:
- ALUC_W, 3, ALU control width (≥3); upper bits beyond [2:0] are always 0.
- MEM_LAT, 1, cycles spent in MEM (≥1).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26]; sampled only in DECODE.
- funct  in  6  instr[5:0]; sampled only in DECODE.
- rt  in  5  instr[20:16]; sampled only in DECODE.
- zero  in  1  ALU zero flag (beq).
- sign  in  1  rs[31] (bgezal).
- hold  in  1  freeze request.
- PCWrite, IRWrite, GRFWrite, DMWrite  out  1  write enables.
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 GRF[rs].
- GRFDst  out  2  00 rt, 01 rd, 10 $31.
- ALUSrc, DMtoGRF, LUI, signSrc  out  1  datapath mux selects.
- ALUC  out  ALUC_W  ALU operation.
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4.
- instr_done  out  1  one-cycle pulse on last cycle of each instruction.
- illegal  out  1  one-cycle pulse in DECODE for undecodable instruction.
- retired  out  CNT_W  count of completed legal instructions.

## Operation
- Decode (in DECODE): addu op 000000/funct 100001; subu 000000/100011; jr 000000/001000; ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011; bgezal op 000001/rt 10001. Anything else is illegal. Class latched into an internal register at DECODE exit; later states use only the latched class.
- Sequences: addu/subu/ori/lui F,D,E,W. lw F,D,E,M,W. sw F,D,E,M. beq F,D,E. bgezal F,D,E,W. j/jr F,D. jal F,D,W. Illegal F,D.
- FETCH: IRWrite=1, PCWrite=1, pc_sel=00.
- DECODE: j/jal PCWrite=1 pc_sel=10; jr PCWrite=1 pc_sel=11.
- EXEC: ALUC = 010 addu/lw/sw, 110 subu, 001 ori/lui, 000 otherwise. ALUSrc=1 for ori/lw/sw/lui. signSrc=1 for ori (zero-extend). beq: PCWrite=zero, pc_sel=01. bgezal: PCWrite=~sign, pc_sel=01.
- MEM: counter loads MEM_LAT-1 on entry and counts down; exit when 0. DMWrite=1 for sw in first MEM cycle only. DMtoGRF=1 throughout lw MEM and WB.
- WB: GRFWrite=1. GRFDst 01 addu/subu, 00 ori/lui/lw, 10 jal/bgezal (link written regardless of branch outcome). LUI=1 for lui.
- ALUC, ALUSrc, signSrc, LUI hold their class value in all states after DECODE exit; 0 in FETCH/DECODE.
- instr_done=1 in the cycle whose next state is FETCH (legal and illegal). retired increments on that edge for legal instructions only; wraps from all-ones to 0.
- hold=1: state, MEM counter and retired frozen; PCWrite, IRWrite, GRFWrite, DMWrite, instr_done, illegal forced 0; mux selects unchanged.

## Timing
- reset=0: state=FETCH, class=none, counter=0, retired=0; all outputs 0 while reset is low (write enables gated by reset). Reset mid-instruction aborts it with no further writes.
- First rising edge after reset release is a FETCH cycle with IRWrite=PCWrite=1.
- Latencies (MEM_LAT=1, no hold): j/jr 2, jal/beq/illegal 2-3, sw 4, ALU ops/bgezal 4, lw 5; MEM adds MEM_LAT-1.
- hold asserted in a sw first MEM cycle delays DMWrite until the first non-hold cycle; exactly one DMWrite pulse per sw.

## Configuration
- CTRL_BGEZAL_EN: defined, bgezal decoded as above. Undefined, op 000001 decodes illegal, no link write, no counter increment.

## Test plan
- addu then lw (MEM_LAT=1): states 0,1,2,4 then 0,1,2,3,4; GRFDst 01 then 00; retired 0→2.
- beq zero=1 vs zero=0: PCWrite=1 pc_sel=01 in EXEC only when zero=1; 3-cycle latency both.
- MEM_LAT=3 sw: MEM held 3 cycles, DMWrite high exactly first MEM cycle, instr_done in last.
- bgezal sign=1: no branch, GRFWrite=1 GRFDst=10 in WB; undefined macro: illegal pulse, retired unchanged.
- op 111111: illegal and instr_done pulse in DECODE, no writes, back to FETCH.
- reset low during lw MEM, hold high 5 cycles during EXEC: all outputs 0 / frozen, retired unchanged, restart at FETCH.
